// File: rtl/led_pixel_serializer_pkg.sv
// Shared types and constants for the WS2812 pixel serializer.
// Optional build macro used by the serializer: LED_BRIGHTNESS_EN.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } led_state_e;

    localparam int unsigned BITS_PER_PIXEL = 24;
    localparam int unsigned CHANNEL_W      = 8;

    // Channel offsets inside a {G, R, B} pixel word
    localparam int unsigned G_OFS = 16;
    localparam int unsigned R_OFS = 8;
    localparam int unsigned B_OFS = 0;

    // Width of the shared bit/latch cycle counter; never narrower than 1 bit
    function automatic int unsigned cnt_width(input int unsigned bit_cycles,
                                              input int unsigned reset_cycles);
        int unsigned m;
        m = (bit_cycles > reset_cycles) ? bit_cycles : reset_cycles;
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/led_channel_scale.sv
// Combinational brightness scaling of one 8-bit colour channel:
// out = (chan * (brightness + 1)) >> 8, so 255 is identity and 0 is black.
module led_channel_scale
    import led_pkg::*;
(
    input  logic [CHANNEL_W-1:0] chan_in,
    input  logic [CHANNEL_W-1:0] brightness_in,
    output logic [CHANNEL_W-1:0] chan_out
);

    localparam int unsigned PROD_W = 2 * CHANNEL_W + 1;

    logic [PROD_W-1:0] product;

    // Multiply by (brightness + 1) and keep the upper channel-width bits
    always_comb begin
        product  = PROD_W'(chan_in) * (PROD_W'(brightness_in) + PROD_W'(1));
        chan_out = CHANNEL_W'(product >> CHANNEL_W);
    end

endmodule

// File: rtl/led_pixel_serializer.sv
// WS2812 NRZ serializer: shifts 24-bit GRB pixels MSB first onto strip_out,
// emits one pixel_done_out pulse per pixel and inserts the latch low period
// at frame end. Build macro LED_BRIGHTNESS_EN adds brightness_in scaling
// applied to each channel at pixel acceptance.
module led_pixel_serializer
    import led_pkg::*;
#(
    parameter int unsigned T0H_CYCLES   = 35,
    parameter int unsigned T1H_CYCLES   = 70,
    parameter int unsigned BIT_CYCLES   = 125,
    parameter int unsigned RESET_CYCLES = 8000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [23:0] pixel_in,
    input  logic        pixel_valid_in,
    output logic        pixel_ready_out,
    input  logic        frame_end_in,
    output logic        strip_out,
    output logic        pixel_done_out,
    output logic        busy_out
`ifdef LED_BRIGHTNESS_EN
    ,
    input  logic [7:0]  brightness_in
`endif
);

    localparam int unsigned CNT_W = cnt_width(BIT_CYCLES, RESET_CYCLES);
    localparam int unsigned IDX_W = $clog2(BITS_PER_PIXEL);

    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(T1H_CYCLES);
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(BITS_PER_PIXEL - 1);

    led_state_e                  state_q, state_d;
    logic [BITS_PER_PIXEL-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        pend_q, pend_d;
    logic                        strip_q, strip_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;

    logic                        bit_end;
    logic                        pix_end;
    logic                        ready;
    logic                        xfer;
    logic [BITS_PER_PIXEL-1:0]   load_pix;

`ifdef LED_BRIGHTNESS_EN
    logic [CHANNEL_W-1:0] g_scaled, r_scaled, b_scaled;

    led_channel_scale u_scale_g (
        .chan_in       (pixel_in[G_OFS +: CHANNEL_W]),
        .brightness_in (brightness_in),
        .chan_out      (g_scaled)
    );

    led_channel_scale u_scale_r (
        .chan_in       (pixel_in[R_OFS +: CHANNEL_W]),
        .brightness_in (brightness_in),
        .chan_out      (r_scaled)
    );

    led_channel_scale u_scale_b (
        .chan_in       (pixel_in[B_OFS +: CHANNEL_W]),
        .brightness_in (brightness_in),
        .chan_out      (b_scaled)
    );

    assign load_pix = {g_scaled, r_scaled, b_scaled};
`else
    assign load_pix = pixel_in;
`endif

    // Bit/pixel boundary decode and the pixel handshake
    always_comb begin
        bit_end = (cnt_q == BIT_LAST);
        pix_end = (state_q == SEND) && bit_end && (idx_q == '0);
        ready   = !rst_in && ((state_q == IDLE) || (pix_end && !pend_q));
        xfer    = pixel_valid_in && ready;
    end

    assign pixel_ready_out = ready;

    // State register and registered outputs, synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            strip_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            strip_q <= strip_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: bit timing, shifting, pixel chaining and latch entry
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SEND;
                    shift_d = load_pix;
                    idx_d   = IDX_TOP;
                    cnt_d   = '0;
                    pend_d  = frame_end_in;
                end else if (frame_end_in) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (frame_end_in) begin
                    pend_d = 1'b1;
                end
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q != '0) begin
                        shift_d = {shift_q[BITS_PER_PIXEL-2:0], 1'b0};
                        idx_d   = idx_q - 1'b1;
                    end else if (xfer) begin
                        shift_d = load_pix;
                        idx_d   = IDX_TOP;
                    end else if (pend_q || frame_end_in) begin
                        // A frame end arriving on the final bit cycle still
                        // latches straight away rather than idling first.
                        state_d = LATCH;
                        pend_d  = 1'b0;
                        shift_d = '0;
                    end else begin
                        state_d = IDLE;
                        shift_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                pend_d = 1'b0;
                if (cnt_q == RESET_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Output decode from next state so the registered line tracks the bit timing
    always_comb begin
        strip_d = (state_d == SEND) &&
                  (cnt_d < (shift_d[BITS_PER_PIXEL-1] ? T1H_C : T0H_C));
        done_d  = pix_end;
        busy_d  = (state_d != IDLE);
    end

    assign strip_out      = strip_q;
    assign pixel_done_out = done_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_led_pixel_serializer.sv
// Self-checking bench for led_pixel_serializer with short timing parameters.
// Expected waveforms come from the NRZ rules applied to the pixel sequence.
module tb_led_pixel_serializer;

    localparam int T0H   = 2;
    localparam int T1H   = 4;
    localparam int BITC  = 6;
    localparam int RSTC  = 10;
    localparam int PIXC  = 24 * BITC;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [23:0] pixel_in = '0;
    logic        pixel_valid_in = 1'b0;
    logic        pixel_ready_out;
    logic        frame_end_in = 1'b0;
    logic        strip_out;
    logic        pixel_done_out;
    logic        busy_out;
`ifdef LED_BRIGHTNESS_EN
    logic [7:0]  brightness_in = 8'd255;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] stream [0:3];

    led_pixel_serializer #(
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .BIT_CYCLES   (BITC),
        .RESET_CYCLES (RSTC)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .pixel_in        (pixel_in),
        .pixel_valid_in  (pixel_valid_in),
        .pixel_ready_out (pixel_ready_out),
        .frame_end_in    (frame_end_in),
        .strip_out       (strip_out),
        .pixel_done_out  (pixel_done_out),
        .busy_out        (busy_out)
`ifdef LED_BRIGHTNESS_EN
        ,
        .brightness_in   (brightness_in)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Pixel as it should appear on the wire
    function automatic logic [23:0] model_pixel(input logic [23:0] p);
`ifdef LED_BRIGHTNESS_EN
        int g, r, b;
        g = (int'(p[23:16]) * (int'(brightness_in) + 1)) / 256;
        r = (int'(p[15:8])  * (int'(brightness_in) + 1)) / 256;
        b = (int'(p[7:0])   * (int'(brightness_in) + 1)) / 256;
        return {g[7:0], r[7:0], b[7:0]};
`else
        return p;
`endif
    endfunction

    // Line level k cycles into a pixel: MSB first, high for T1H or T0H of each bit
    function automatic logic exp_level(input logic [23:0] p, input int k);
        int b;
        int c;
        logic v;
        b = k / BITC;
        c = k % BITC;
        v = p[23 - b];
        return (c < (v ? T1H : T0H));
    endfunction

    // Sends stream[0..n-1] with valid held; checks every cycle of the pixels
    task automatic run_stream(input int n);
        logic [23:0] expv [0:3];
        int idx;
        for (int i = 0; i < n; i++) begin
            expv[i] = model_pixel(stream[i]);
        end
        pixel_in       = stream[0];
        pixel_valid_in = 1'b1;
        check_eq("ready_idle", pixel_ready_out, 1);
        tick();
        idx = 1;
        if (n > 1) pixel_in = stream[1];
        else       pixel_valid_in = 1'b0;
        for (int k = 0; k < n * PIXC; k++) begin
            check_eq($sformatf("strip_k%0d", k), strip_out, exp_level(expv[k / PIXC], k % PIXC));
            check_eq("done_mid", pixel_done_out, (k > 0) && (k % PIXC == 0));
            check_eq("ready_send", pixel_ready_out, (k % PIXC) == PIXC - 1);
            check_eq("busy_send", busy_out, 1);
            tick();
            if ((k % PIXC == PIXC - 1) && idx < n) begin
                idx++;
                if (idx < n) pixel_in = stream[idx];
                else         pixel_valid_in = 1'b0;
            end
        end
        check_eq("done_end", pixel_done_out, 1);
        check_eq("strip_end", strip_out, 0);
        check_eq("busy_end", busy_out, 0);
        check_eq("ready_end", pixel_ready_out, 1);
        tick();
        check_eq("done_once", pixel_done_out, 0);
    endtask

    task automatic check_latch(input logic first_done);
        for (int j = 0; j < RSTC; j++) begin
            check_eq("latch_strip", strip_out, 0);
            check_eq("latch_ready", pixel_ready_out, 0);
            check_eq("latch_busy", busy_out, 1);
            check_eq("latch_done", pixel_done_out, (j == 0) && first_done);
            tick();
        end
        check_eq("post_latch_busy", busy_out, 0);
        check_eq("post_latch_ready", pixel_ready_out, 1);
        check_eq("post_latch_strip", strip_out, 0);
    endtask

    initial begin
        // Reset held for three cycles
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_strip", strip_out, 0);
            check_eq("rst_done", pixel_done_out, 0);
            check_eq("rst_busy", busy_out, 0);
            check_eq("rst_ready", pixel_ready_out, 0);
        end
        rst_in = 1'b0;
        #1;
        check_eq("ready_after_rst", pixel_ready_out, 1);
        tick();

        // Single pixel with distinct first/last bits
        stream[0] = 24'h800001;
        run_stream(1);

        // Back-to-back all ones then all zeros
        stream[0] = 24'hFFFFFF;
        stream[1] = 24'h000000;
        run_stream(2);

        // Frame end while idle latches at once
        frame_end_in = 1'b1;
        tick();
        frame_end_in = 1'b0;
        check_latch(1'b0);
        tick();

        // Frame end mid-pixel with the next pixel already offered
        stream[0] = $urandom();
        stream[1] = $urandom();
        pixel_in       = stream[0];
        pixel_valid_in = 1'b1;
        tick();
        pixel_in = stream[1];
        for (int k = 0; k < PIXC; k++) begin
            check_eq("fe_strip", strip_out, exp_level(model_pixel(stream[0]), k));
            check_eq("fe_ready", pixel_ready_out, 0);
            if (k == 50) frame_end_in = 1'b1;
            tick();
            frame_end_in = 1'b0;
        end
        check_latch(1'b1);
        stream[0] = stream[1];
        run_stream(1);

        // Reset in the middle of a pixel
        pixel_in       = $urandom();
        pixel_valid_in = 1'b1;
        tick();
        pixel_valid_in = 1'b0;
        for (int k = 0; k < 50; k++) tick();
        rst_in = 1'b1;
        tick();
        check_eq("midrst_strip", strip_out, 0);
        check_eq("midrst_done", pixel_done_out, 0);
        check_eq("midrst_busy", busy_out, 0);
        check_eq("midrst_ready", pixel_ready_out, 0);
        rst_in = 1'b0;
        tick();
        check_eq("midrst_done2", pixel_done_out, 0);
        stream[0] = $urandom();
        run_stream(1);

`ifdef LED_BRIGHTNESS_EN
        // Brightness 127 on full white
        brightness_in = 8'd127;
        stream[0] = 24'hFFFFFF;
        check_eq("scale_model", model_pixel(stream[0]), 24'h7F7F7F);
        run_stream(1);
`endif

        // Randomized streams and gaps
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) stream[i] = $urandom();
`ifdef LED_BRIGHTNESS_EN
            brightness_in = 8'($urandom());
`endif
            run_stream(n);
            for (int g = 0; g < int'($urandom_range(0, 4)); g++) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
